bnn_job_scheduler: RTL and testbench
====================================

# bnn_job_scheduler

Job-level controller for the binary PE-array datapath. Accepts layer-slice descriptors on a valid/ready queue and sequences SRAM read addresses and the array clock-enable for each job. It accumulates the per-cycle popcount reduction returned by the array and emits one result per job on a valid/ready output. It sits between the host/command path and the weight/activation SRAM read port plus the PE-array reduction tree.

## Interface
- WORD_SIZE, 64, bit width of one SRAM word (informational; sets SUM_W default)
- SRAM_DEPTH, 64, words per SRAM
- ADDR_W, 6, SRAM address width; SRAM_DEPTH ≤ 2^ADDR_W
- SUM_W, 13, width of per-cycle reduced popcount input
- ACC_W, 32, accumulator/result width
- FIFO_DEPTH, 4, descriptor queue entries; power of two
- PIPE_LAT, 1, cycles from rd_en cycle to the matching sum_in cycle; ≥1
- clk  in  1  clock, all logic rising-edge
- reset  in  1  synchronous, active-high; clears all state
- job_valid  in  1  descriptor offered
- job_ready  out  1  queue not full
- job_base  in  ADDR_W  first SRAM word of job
- job_len  in  ADDR_W+1  words to process
- job_id  in  4  tag echoed on result
- job_thresh  in  ACC_W  binarization threshold (used only with macro)
- rd_en  out  1  SRAM read strobe
- rd_addr  out  ADDR_W  SRAM read address
- array_ce  out  1  PE-array clock enable
- sum_in  in  SUM_W  reduced popcount from array
- res_valid  out  1  result held
- res_ready  in  1  result consumer accepts
- res_sum  out  ACC_W  accumulated popcount
- res_id  out  4  echoed job_id
- res_err  out  1  job rejected (bad length/range)
- res_bit  out  1  binarized output (0 without macro)
- busy  out  1  state ≠ IDLE or queue non-empty

## Operation
- Queue: push on job_valid&&job_ready; job_ready = !full; no push when full (descriptor ignored, not an error). Pop only in IDLE when non-empty. Push and pop in the same cycle are both honoured.
- States: IDLE, ISSUE, DRAIN, OUT.
- IDLE: if queue non-empty, pop and latch descriptor. If job_len==0 or job_base+job_len > SRAM_DEPTH, go to OUT with res_err=1, res_sum=0, res_bit=0. Otherwise clear accumulator, issued and received counters, and go to ISSUE.
- ISSUE: rd_en=1, rd_addr=base+issued, issued++. After the len-th strobe, go to DRAIN (or directly to OUT if received reaches len on the same edge).
- A PIPE_LAT-deep valid shift register tracks rd_en. When its output is high, acc += sum_in, zero-extended, saturating at 2^ACC_W−1, and received++.
- DRAIN: rd_en=0. When received==len, go to OUT.
- array_ce = 1 in ISSUE and DRAIN, else 0.
- OUT: res_valid=1; res_* are stable until res_valid&&res_ready, then go to IDLE. Back-to-back jobs therefore have one IDLE cycle between OUT and ISSUE.
- rd_addr never wraps; range is checked before issue.

## Timing
- Reset values: job_ready=1, rd_en=0, rd_addr=0, array_ce=0, res_valid=0, res_sum=0, res_id=0, res_err=0, res_bit=0, busy=0. Queue is flushed, accumulator is cleared, valid pipe is cleared.
- Reset asserted mid-job aborts it: in-flight sums are discarded and no result is emitted.
- For a valid job popped in IDLE cycle t: rd_en is high in cycles t+1..t+len; sum_in for strobe i (0-based) is sampled at the end of cycle t+1+i+PIPE_LAT; res_valid rises in cycle t+len+PIPE_LAT+1.
- For a rejected job popped in cycle t: res_valid rises in cycle t+1.
- res_valid and res_* are registered outputs. sum_in is sampled only when the valid pipe is high; other values are ignored.
- job_ready deasserts the cycle after the push that fills the queue.

## Configuration
- BNN_SCHED_THRESH_EN defined: job_thresh is stored with each descriptor, and res_bit = (res_sum ≥ thresh) for non-error results.
- Undefined: job_thresh is not stored (input ignored), res_bit is tied to 0, and queue storage shrinks by ACC_W per entry.

## Test plan
- Reset, push base=0 len=64 id=3, drive sum_in=64 on each pipe-valid cycle -> rd_addr 0..63 in consecutive cycles; res_valid at pop+66 (PIPE_LAT=1); res_sum=4096, res_id=3, res_err=0.
- Push base=60 len=8 -> no rd_en; res_valid at pop+1 with res_err=1, res_sum=0. Repeat with len=0 -> same result.
- Push 5 jobs while res_ready=0 -> job_ready low after the 4th queued; the 5th is ignored. Drain all results -> 4 results in order of id.
- Hold res_ready=0 for 10 cycles in OUT -> res_* stable, no rd_en; after accept, the next job's rd_en starts 2 cycles later.
- Assert reset at the 5th cycle of ISSUE -> all outputs return to reset values next cycle, no result emitted, queue empty.
- With BNN_SCHED_THRESH_EN: len=4, sum_in=10, thresh=40 -> res_bit=1. With thresh=41 -> res_bit=0.

Source files
------------

// File: rtl/bnn_job_scheduler.sv
// bnn_job_scheduler
// Job-level controller for the binary PE array. Descriptors enter a small
// queue; a four-state FSM (IDLE/ISSUE/DRAIN/OUT) pops one, range-checks it,
// strobes the SRAM read port once per word while enabling the array, sums the
// popcount that comes back PIPE_LAT cycles later and presents one registered
// result per job.
//
// Optional feature macro: BNN_SCHED_THRESH_EN. When defined, each descriptor
// carries a threshold and res_bit = (res_sum >= threshold) on good results.
// When undefined, job_thresh is ignored and res_bit is always 0.
//
// Handshakes (job_* and res_*): a transfer occurs on the rising edge where
// valid && ready are both high. The producer holds valid and payload steady
// until that edge. Neither ready output depends combinationally on valid.
module bnn_job_scheduler #(
  parameter int WORD_SIZE  = 64,
  parameter int SRAM_DEPTH = 64,
  parameter int ADDR_W     = 6,
  parameter int SUM_W      = $clog2(WORD_SIZE * SRAM_DEPTH) + 1,
  parameter int ACC_W      = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int PIPE_LAT   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [ADDR_W-1:0] job_base,
  input  logic [ADDR_W:0]   job_len,
  input  logic [3:0]        job_id,
  input  logic [ACC_W-1:0]  job_thresh,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              array_ce,
  input  logic [SUM_W-1:0]  sum_in,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_sum,
  output logic [3:0]        res_id,
  output logic              res_err,
  output logic              res_bit,
  output logic              busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LEN_W = ADDR_W + 1;
  localparam logic [PTR_W:0]    FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_W+1:0] DEPTH_LIM = (ADDR_W + 2)'(SRAM_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t state_q, state_d;

  // ---------------------------------------------------------------------------
  // Descriptor queue
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] fifo_base_q [FIFO_DEPTH];
  logic [LEN_W-1:0]  fifo_len_q  [FIFO_DEPTH];
  logic [3:0]        fifo_id_q   [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              fifo_full, fifo_empty, push, pop;

  assign fifo_full  = (count_q == FIFO_FULL);
  assign fifo_empty = (count_q == '0);
  assign push       = job_valid && !fifo_full;
  assign pop        = (state_q == S_IDLE) && !fifo_empty;
  assign job_ready  = !fifo_full;

  // Queue pointers and occupancy; simultaneous push and pop leave count as is
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Queue payload storage; validity is defined by the pointers alone
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_base_q[wr_ptr_q] <= job_base;
      fifo_len_q[wr_ptr_q]  <= job_len;
      fifo_id_q[wr_ptr_q]   <= job_id;
    end
  end

`ifdef BNN_SCHED_THRESH_EN
  logic [ACC_W-1:0] fifo_thresh_q [FIFO_DEPTH];
  logic [ACC_W-1:0] thresh_q, thresh_d;

  // Threshold payload travels alongside the rest of the descriptor
  always_ff @(posedge clk) begin
    if (push) fifo_thresh_q[wr_ptr_q] <= job_thresh;
  end
`else
  logic unused_thresh;
  assign unused_thresh = ^job_thresh;
`endif

  // Head-of-queue descriptor and its range check
  logic [ADDR_W-1:0] head_base;
  logic [LEN_W-1:0]  head_len;
  logic [3:0]        head_id;
  logic [ADDR_W+1:0] head_end;
  logic              head_bad;

  assign head_base = fifo_base_q[rd_ptr_q];
  assign head_len  = fifo_len_q[rd_ptr_q];
  assign head_id   = fifo_id_q[rd_ptr_q];
  assign head_end  = {2'b00, head_base} + {1'b0, head_len};
  assign head_bad  = (head_len == '0) || (head_end > DEPTH_LIM);

  // ---------------------------------------------------------------------------
  // Job context, return-path tracking and accumulator
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [3:0]          id_q, id_d;
  logic [LEN_W-1:0]    issued_q, issued_d;
  logic [LEN_W-1:0]    recv_q, recv_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [PIPE_LAT-1:0] vld_pipe_q, vld_pipe_d;
  logic                res_valid_q, res_valid_d;
  logic [ACC_W-1:0]    res_sum_q, res_sum_d;
  logic [3:0]          res_id_q, res_id_d;
  logic                res_err_q, res_err_d;
  logic                res_bit_q, res_bit_d;

  logic                pipe_out, issue_last, recv_last;
  logic [ACC_W:0]      acc_wide;
  logic [ACC_W-1:0]    acc_add;
  logic [LEN_W-1:0]    issued_inc, recv_inc;

  // Valid pipe mirrors the SRAM/array latency so we know when sum_in is real
  assign vld_pipe_d = PIPE_LAT'({vld_pipe_q, rd_en});
  assign pipe_out   = vld_pipe_q[PIPE_LAT-1];

  // Zero-extended add that pins at all-ones instead of wrapping
  assign acc_wide   = {1'b0, acc_q} + (ACC_W + 1)'(sum_in);
  assign acc_add    = acc_wide[ACC_W] ? {ACC_W{1'b1}} : acc_wide[ACC_W-1:0];

  assign issued_inc = issued_q + LEN_W'(1);
  assign recv_inc   = recv_q + LEN_W'(1);
  assign issue_last = (issued_inc == len_q);
  assign recv_last  = pipe_out && (recv_inc == len_q);

  // FSM next state, read sequencing, accumulation and result capture
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    id_d        = id_q;
    issued_d    = issued_q;
    recv_d      = recv_q;
    acc_d       = acc_q;
    res_valid_d = res_valid_q;
    res_sum_d   = res_sum_q;
    res_id_d    = res_id_q;
    res_err_d   = res_err_q;
    res_bit_d   = res_bit_q;
`ifdef BNN_SCHED_THRESH_EN
    thresh_d    = thresh_q;
`endif
    rd_en       = 1'b0;
    rd_addr     = '0;
    array_ce    = 1'b0;

    if (pipe_out) begin
      acc_d  = acc_add;
      recv_d = recv_inc;
    end

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          base_d = head_base;
          len_d  = head_len;
          id_d   = head_id;
`ifdef BNN_SCHED_THRESH_EN
          thresh_d = fifo_thresh_q[rd_ptr_q];
`endif
          if (head_bad) begin
            state_d     = S_OUT;
            res_valid_d = 1'b1;
            res_err_d   = 1'b1;
            res_sum_d   = '0;
            res_bit_d   = 1'b0;
            res_id_d    = head_id;
          end else begin
            state_d  = S_ISSUE;
            acc_d    = '0;
            recv_d   = '0;
            issued_d = '0;
          end
        end
      end
      S_ISSUE: begin
        rd_en    = 1'b1;
        array_ce = 1'b1;
        rd_addr  = base_q + issued_q[ADDR_W-1:0];
        issued_d = issued_inc;
        if (issue_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        array_ce = 1'b1;
      end
      S_OUT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Last sum arriving finishes the job from either ISSUE or DRAIN
    if (((state_q == S_ISSUE) || (state_q == S_DRAIN)) && recv_last) begin
      state_d     = S_OUT;
      res_valid_d = 1'b1;
      res_err_d   = 1'b0;
      res_sum_d   = acc_add;
      res_id_d    = id_q;
`ifdef BNN_SCHED_THRESH_EN
      res_bit_d   = (acc_add >= thresh_q);
`else
      res_bit_d   = 1'b0;
`endif
    end
  end

  // State, queue pointers, job context and registered result
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      base_q      <= '0;
      len_q       <= '0;
      id_q        <= '0;
      issued_q    <= '0;
      recv_q      <= '0;
      acc_q       <= '0;
      vld_pipe_q  <= '0;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_id_q    <= '0;
      res_err_q   <= 1'b0;
      res_bit_q   <= 1'b0;
`ifdef BNN_SCHED_THRESH_EN
      thresh_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      base_q      <= base_d;
      len_q       <= len_d;
      id_q        <= id_d;
      issued_q    <= issued_d;
      recv_q      <= recv_d;
      acc_q       <= acc_d;
      vld_pipe_q  <= vld_pipe_d;
      res_valid_q <= res_valid_d;
      res_sum_q   <= res_sum_d;
      res_id_q    <= res_id_d;
      res_err_q   <= res_err_d;
      res_bit_q   <= res_bit_d;
`ifdef BNN_SCHED_THRESH_EN
      thresh_q    <= thresh_d;
`endif
    end
  end

  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_id    = res_id_q;
  assign res_err   = res_err_q;
  assign res_bit   = res_bit_q;
  assign busy      = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_bnn_job_scheduler.sv
// Directed bench for bnn_job_scheduler (default parameters, PIPE_LAT=1).
// Expected values are hand-computed from the job descriptors and the
// array model's sum pattern.
module tb_bnn_job_scheduler;

  // ---------------- clock / reset block ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        job_valid;
  logic        job_ready;
  logic [5:0]  job_base;
  logic [6:0]  job_len;
  logic [3:0]  job_id;
  logic [31:0] job_thresh;
  logic        rd_en;
  logic [5:0]  rd_addr;
  logic        array_ce;
  logic [12:0] sum_in;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_sum;
  logic [3:0]  res_id;
  logic        res_err;
  logic        res_bit;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int sum_mode = 0;
  logic [36:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bnn_job_scheduler dut (
    .clk(clk), .reset(reset),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_base(job_base), .job_len(job_len), .job_id(job_id), .job_thresh(job_thresh),
    .rd_en(rd_en), .rd_addr(rd_addr), .array_ce(array_ce), .sum_in(sum_in),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_id(res_id), .res_err(res_err), .res_bit(res_bit),
    .busy(busy)
  );

  // ---------------- array / SRAM model ----------------
  function automatic logic [12:0] model_sum(input logic [5:0] a);
    case (sum_mode)
      1:       model_sum = 13'(3 * a + 1);
      2:       model_sum = 13'd10;
      default: model_sum = 13'd64;
    endcase
  endfunction

  // One-cycle return path: strobe seen in cycle n -> sum driven in cycle n+1
  initial begin : array_model
    logic       pv;
    logic [5:0] pa;
    pv = 1'b0;
    pa = '0;
    sum_in = 13'h1fff;
    forever begin
      @(negedge clk);
      if (pv) sum_in = model_sum(pa);
      else    sum_in = 13'h1fff;
      pv = rd_en;
      pa = rd_addr;
    end
  end

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_job_ready"}, job_ready, 1);
    check({tag, "_rd_en"},     rd_en,     0);
    check({tag, "_rd_addr"},   rd_addr,   0);
    check({tag, "_array_ce"},  array_ce,  0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_sum"},   res_sum,   0);
    check({tag, "_res_id"},    res_id,    0);
    check({tag, "_res_err"},   res_err,   0);
    check({tag, "_res_bit"},   res_bit,   0);
    check({tag, "_busy"},      busy,      0);
  endtask

  // Push one job at this negedge and follow it until its result appears.
  // Returns strobe start and result latency relative to the push cycle.
  task automatic run_job(input logic [5:0] b, input logic [6:0] l, input logic [3:0] id,
                         input logic [31:0] th, output int d_rd, output int n_rd,
                         output int d_res);
    int t0;
    bit seen;
    job_base = b; job_len = l; job_id = id; job_thresh = th; job_valid = 1'b1;
    t0 = cyc;
    tick(1);
    job_valid = 1'b0;
    d_rd = -1; n_rd = 0; d_res = -1; seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      if (res_valid) begin
        d_res = cyc - t0;
        seen = 1'b1;
        check("res_rd_quiet", rd_en, 0);
        check("res_ce_quiet", array_ce, 0);
      end else begin
        if (rd_en) begin
          if (n_rd == 0) d_rd = cyc - t0;
          check("rd_addr", rd_addr, b + n_rd);
          check("array_ce", array_ce, 1);
          n_rd++;
        end
        tick(1);
      end
    end
    if (!seen) check("res_timeout", 0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d_rd, n_rd, d_res, cnt, t0, n_seen;
    logic [36:0] e;

    reset = 1'b1; job_valid = 1'b0; job_base = '0; job_len = '0; job_id = '0;
    job_thresh = '0; res_ready = 1'b0;
    tick(2);
    check_reset_outputs("rst");
    reset = 1'b0;
    tick(1);

    // Full-depth job, constant 64 per cycle
    res_ready = 1'b1; sum_mode = 0;
    run_job(6'd0, 7'd64, 4'd3, 32'd0, d_rd, n_rd, d_res);
    check("t1_rd_start", d_rd, 2);
    check("t1_rd_count", n_rd, 64);
    check("t1_res_lat", d_res, 67);
    check("t1_sum", res_sum, 4096);
    check("t1_id", res_id, 3);
    check("t1_err", res_err, 0);
    check("t1_bit", res_bit, 0);
    tick(1);
    check("t1_res_drop", res_valid, 0);
    check("t1_busy", busy, 0);

    // Address-dependent sums, including the last-word boundary
    sum_mode = 1;
    run_job(6'd10, 7'd5, 4'd4, 32'd0, d_rd, n_rd, d_res);
    check("t2a_rd_start", d_rd, 2);
    check("t2a_rd_count", n_rd, 5);
    check("t2a_res_lat", d_res, 8);
    check("t2a_sum", res_sum, 185);
    check("t2a_id", res_id, 4);
    run_job(6'd60, 7'd4, 4'd2, 32'd0, d_rd, n_rd, d_res);
    check("t2b_rd_count", n_rd, 4);
    check("t2b_res_lat", d_res, 7);
    check("t2b_sum", res_sum, 742);
    check("t2b_err", res_err, 0);
    run_job(6'd63, 7'd1, 4'd15, 32'd0, d_rd, n_rd, d_res);
    check("t2c_res_lat", d_res, 4);
    check("t2c_sum", res_sum, 190);
    check("t2c_id", res_id, 15);

    // Rejected descriptors: out of range, zero length, over-length
    run_job(6'd60, 7'd8, 4'd5, 32'd0, d_rd, n_rd, d_res);
    check("t3a_rd_count", n_rd, 0);
    check("t3a_res_lat", d_res, 2);
    check("t3a_err", res_err, 1);
    check("t3a_sum", res_sum, 0);
    check("t3a_id", res_id, 5);
    run_job(6'd0, 7'd0, 4'd6, 32'd0, d_rd, n_rd, d_res);
    check("t3b_rd_count", n_rd, 0);
    check("t3b_res_lat", d_res, 2);
    check("t3b_err", res_err, 1);
    check("t3b_sum", res_sum, 0);
    check("t3b_id", res_id, 6);
    run_job(6'd0, 7'd65, 4'd7, 32'd0, d_rd, n_rd, d_res);
    check("t3c_res_lat", d_res, 2);
    check("t3c_err", res_err, 1);
    check("t3c_bit", res_bit, 0);
    tick(1);

    // Queue fill while a long job runs and results are back-pressured
    sum_mode = 1; res_ready = 1'b0;
    exp_q.delete();
    job_base = 6'd0; job_len = 7'd64; job_id = 4'd1; job_valid = 1'b1;
    exp_q.push_back({1'b0, 4'd1, 32'd6112});
    tick(1);
    job_valid = 1'b0;
    tick(3);
    check("t4_issuing", rd_en, 1);
    for (int k = 0; k < 5; k++) begin
      check("t4_job_ready", job_ready, (k < 4));
      job_base = 6'(4 * k); job_len = 7'd2; job_id = 4'(8 + k); job_valid = 1'b1;
      if (k < 4) exp_q.push_back({1'b0, 4'(8 + k), 32'(24 * k + 5)});
      tick(1);
    end
    job_valid = 1'b0;
    check("t4_full", job_ready, 0);
    check("t4_busy", busy, 1);
    res_ready = 1'b1;
    n_seen = 0;
    for (int i = 0; i < 1000 && exp_q.size() > 0; i++) begin
      if (res_valid) begin
        e = exp_q.pop_front();
        check("t4_res", {res_err, res_id, res_sum}, e);
        n_seen++;
      end
      tick(1);
    end
    check("t4_left", exp_q.size(), 0);
    check("t4_count", n_seen, 5);
    tick(5);
    check("t4_no_extra", res_valid, 0);
    check("t4_idle", busy, 0);

    // Result held under back-pressure, then back-to-back follow-on job
    res_ready = 1'b0; sum_mode = 1;
    job_base = 6'd0; job_len = 7'd3; job_id = 4'd1; job_valid = 1'b1;
    tick(1);
    job_base = 6'd8; job_len = 7'd2; job_id = 4'd2;
    tick(1);
    job_valid = 1'b0;
    for (int i = 0; i < 50 && !res_valid; i++) tick(1);
    check("t5_res_seen", res_valid, 1);
    for (int i = 0; i < 10; i++) begin
      check("t5_hold_valid", res_valid, 1);
      check("t5_hold_sum", res_sum, 12);
      check("t5_hold_id", res_id, 1);
      check("t5_no_rd", rd_en, 0);
      tick(1);
    end
    res_ready = 1'b1;
    t0 = cyc;
    tick(1);
    for (int i = 0; i < 20 && !rd_en; i++) tick(1);
    check("t5_next_rd", cyc - t0, 2);
    for (int i = 0; i < 50 && !res_valid; i++) tick(1);
    check("t5_res2_seen", res_valid, 1);
    check("t5_res2_sum", res_sum, 53);
    check("t5_res2_id", res_id, 2);
    tick(1);

    // Reset during the fifth ISSUE cycle with one job still queued
    sum_mode = 0;
    job_base = 6'd0; job_len = 7'd20; job_id = 4'd7; job_valid = 1'b1;
    tick(1);
    job_base = 6'd0; job_len = 7'd4; job_id = 4'd9;
    tick(1);
    job_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 30 && cnt < 5; i++) begin
      if (rd_en) cnt++;
      if (cnt < 5) tick(1);
    end
    check("t6_fifth", cnt, 5);
    check("t6_fifth_addr", rd_addr, 4);
    reset = 1'b1;
    tick(1);
    check_reset_outputs("t6");
    reset = 1'b0;
    n_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (rd_en || res_valid) n_seen++;
    end
    check("t6_quiet", n_seen, 0);
    sum_mode = 1;
    run_job(6'd2, 7'd3, 4'd11, 32'd0, d_rd, n_rd, d_res);
    check("t6_after_lat", d_res, 6);
    check("t6_after_sum", res_sum, 30);
    check("t6_after_id", res_id, 11);
    tick(1);

    // Binarization
    sum_mode = 2;
`ifdef BNN_SCHED_THRESH_EN
    run_job(6'd0, 7'd4, 4'd12, 32'd40, d_rd, n_rd, d_res);
    check("t7a_sum", res_sum, 40);
    check("t7a_bit", res_bit, 1);
    run_job(6'd0, 7'd4, 4'd13, 32'd41, d_rd, n_rd, d_res);
    check("t7b_sum", res_sum, 40);
    check("t7b_bit", res_bit, 0);
    run_job(6'd60, 7'd8, 4'd14, 32'd0, d_rd, n_rd, d_res);
    check("t7c_err", res_err, 1);
    check("t7c_bit", res_bit, 0);
`else
    run_job(6'd0, 7'd4, 4'd12, 32'd0, d_rd, n_rd, d_res);
    check("t7_sum", res_sum, 40);
    check("t7_bit", res_bit, 0);
`endif
    tick(2);

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
